inv_sbox_builder: RTL and testbench

Builds the AES inverse S-box into an internal 256x8 RAM at run time by walking the forward S-box table, then serves inverse-SubBytes lookups through a valid/ready request port with a registered response. It sits beside the forward S-box lookup in the decryption datapath. It replaces a second hard-coded table file with a table derived from the forward one, so the two can never disagree.

---
 rtl/aes_tables_pkg.sv | 39 +++
 rtl/sbox_fwd_lut.sv | 31 +++
 rtl/inv_sbox_builder.sv | 183 ++++++++++++++++++
 tb/tb_inv_sbox_builder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/aes_tables_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_tables_pkg
// Description : Shared AES constants: forward S-box, table size, builder FSM
//               state type.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_tables_pkg;

  localparam int SBOX_SIZE = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_CHECK = 2'd2,
    ST_READY = 2'd3
  } inv_build_state_t;

  localparam logic [7:0] FWD_SBOX [SBOX_SIZE] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage
`default_nettype wire

// File: rtl/sbox_fwd_lut.sv
`default_nettype none
// ============================================================================
// Module      : sbox_fwd_lut
// Description : Synchronous-read forward AES S-box, one cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module sbox_fwd_lut
  import aes_tables_pkg::*;
(
  input  logic       clk,
  input  logic       en,
  input  logic [7:0] addr,
  output logic [7:0] data
);

  logic [7:0] data_q;
  logic [7:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en) data_d = FWD_SBOX[addr];
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule
`default_nettype wire

// File: rtl/inv_sbox_builder.sv
`default_nettype none
// ============================================================================
// Module      : inv_sbox_builder
// Description : Derives the AES inverse S-box from the forward table into a
//               256x8 RAM, then serves valid/ready lookups with 1-cycle latency.
//               Optional read-back self-check: INV_SBOX_SELFCHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module inv_sbox_builder
  import aes_tables_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  ready,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = '1;
`ifdef INV_SBOX_SELFCHECK_EN
  localparam inv_build_state_t c_AFTER_FILL = ST_CHECK;
`else
  localparam inv_build_state_t c_AFTER_FILL = ST_READY;
`endif

  inv_build_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] a_q, a_d;
  logic                  rd_done_q, rd_done_d;
  logic                  p1_vld_q, p1_vld_d;
  logic [ADDR_WIDTH-1:0] p1_a_q, p1_a_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [DATA_WIDTH-1:0] inv_mem [SBOX_SIZE];
  logic [DATA_WIDTH-1:0] lut_data;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic                  mem_we;
  logic                  scan;
  logic                  start_ok;
  logic                  fill_done;
  logic                  chk_done;
  logic                  accept;

  sbox_fwd_lut u_fwd_lut (
    .clk  (clk),
    .en   (scan),
    .addr (a_q),
    .data (lut_data)
  );

  // Counter a_q issues forward reads; p1 stage carries a one cycle behind.
  assign scan      = ((state_q == ST_FILL) || (state_q == ST_CHECK)) && !rd_done_q;
  assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_READY));
  assign fill_done = (state_q == ST_FILL) && p1_vld_q && (p1_a_q == c_LAST_ADDR);
  assign accept    = (state_q == ST_READY) && req_valid;
  assign mem_we    = (state_q == ST_FILL) && p1_vld_q;

  assign mem_rd_addr = (state_q == ST_READY) ? req_addr : lut_data;
  assign mem_rdata   = inv_mem[mem_rd_addr];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start)     state_d = ST_FILL;
      ST_FILL:  if (fill_done) state_d = c_AFTER_FILL;
      ST_CHECK: if (chk_done)  state_d = ST_READY;
      ST_READY: if (start)     state_d = ST_FILL;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy      = (state_q == ST_FILL) || (state_q == ST_CHECK);
    ready     = (state_q == ST_READY);
    req_ready = (state_q == ST_READY);
  end

  // ---------------- build / lookup datapath ----------------
  always_comb begin
    a_d         = a_q;
    rd_done_d   = rd_done_q;
    p1_vld_d    = scan;
    p1_a_d      = a_q;
    rsp_valid_d = accept;
    rsp_data_d  = accept ? mem_rdata : rsp_data_q;
    if (scan) begin
      a_d = a_q + 1'b1;
      if (a_q == c_LAST_ADDR) rd_done_d = 1'b1;
    end
    if (start_ok || fill_done) begin
      a_d       = '0;
      rd_done_d = 1'b0;
      p1_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      rd_done_q   <= 1'b0;
      p1_vld_q    <= 1'b0;
      p1_a_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      a_q         <= a_d;
      rd_done_q   <= rd_done_d;
      p1_vld_q    <= p1_vld_d;
      p1_a_q      <= p1_a_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // RAM contents need no reset: they are never served before a full build.
  always_ff @(posedge clk) begin
    if (mem_we) inv_mem[lut_data] <= p1_a_q;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

`ifdef INV_SBOX_SELFCHECK_EN
  logic                  p2_vld_q, p2_vld_d;
  logic [ADDR_WIDTH-1:0] p2_a_q, p2_a_d;
  logic [DATA_WIDTH-1:0] chk_data_q, chk_data_d;
  logic                  err_q, err_d;

  assign chk_done = (state_q == ST_CHECK) && p2_vld_q && (p2_a_q == c_LAST_ADDR);

  // Stage 2 holds inv_mem[fwd[a]] next to a, so the compare is a plain equality.
  always_comb begin
    p2_vld_d   = (state_q == ST_CHECK) && p1_vld_q;
    p2_a_d     = p1_a_q;
    chk_data_d = ((state_q == ST_CHECK) && p1_vld_q) ? mem_rdata : chk_data_q;
    err_d      = err_q | ((state_q == ST_CHECK) && p2_vld_q && (chk_data_q != p2_a_q));
    if (start_ok) begin
      p2_vld_d = 1'b0;
      err_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p2_vld_q   <= 1'b0;
      p2_a_q     <= '0;
      chk_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      p2_vld_q   <= p2_vld_d;
      p2_a_q     <= p2_a_d;
      chk_data_q <= chk_data_d;
      err_q      <= err_d;
    end
  end

  assign err = err_q;
`else
  assign chk_done = 1'b0;
  assign err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inv_sbox_builder.sv
`default_nettype none
// ============================================================================
// Module      : tb_inv_sbox_builder
// Description : Directed self-checking bench for inv_sbox_builder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_sbox_builder;
  import aes_tables_pkg::*;

`ifdef INV_SBOX_SELFCHECK_EN
  localparam int BUILD_CYC = 515;
`else
  localparam int BUILD_CYC = 257;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, ready, req_ready, rsp_valid, err;
  logic       req_valid = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] rsp_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [8];

  inv_sbox_builder #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .ready     (ready),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Cycle numbering: the edge that samples start is edge 0.
  task automatic run_build(input bit pre_started, input bit mid_start, input bit corrupt);
    if (!pre_started) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk("busy_c1", busy, 1'b1);
    chk("ready_c1", ready, 1'b0);
    chk("err_c1", err, 1'b0);
    for (int c = 1; c < BUILD_CYC; c++) begin
      if (mid_start && c == 100) start = 1'b1;
`ifdef INV_SBOX_SELFCHECK_EN
      // a=255 reads fwd[255]=0x16; its compare is the last one of CHECK
      if (corrupt && c == 300) dut.inv_mem[8'h16] = 8'h00;
`endif
      tick();
      start = 1'b0;
    end
    chk("ready_before", {busy, ready}, 2'b10);
    tick();
    chk("ready_rise", {busy, ready, req_ready}, 3'b011);
    chk("err_at_ready", err, {31'd0, corrupt});
  endtask

  task automatic run_vectors(input string tag);
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1;
      req_addr  = vecs[i].addr;
      tick();
      chk({tag, "_vld"}, rsp_valid, 1'b1);
      chk({tag, "_data"}, rsp_data, vecs[i].exp);
    end
    req_valid = 1'b0;
    tick();
    chk({tag, "_idle_vld"}, rsp_valid, 1'b0);
    chk({tag, "_hold"}, rsp_data, vecs[7].exp);
  endtask

  initial begin
    vecs[0] = '{8'h63, 8'h00};
    vecs[1] = '{8'h7C, 8'h01};
    vecs[2] = '{8'h16, 8'hFF};
    vecs[3] = '{8'h00, 8'h52};
    vecs[4] = '{8'h52, 8'h48};
    vecs[5] = '{8'h01, 8'h09};
    vecs[6] = '{8'hFF, 8'h7D};
    vecs[7] = '{8'h10, 8'h7C};

    tick(); tick(); tick();
    chk("rst_outs", {busy, ready, req_ready, rsp_valid, err}, 5'b0);
    chk("rst_data", rsp_data, 8'h00);
    rst = 1'b0;
    tick();
    chk("idle_outs", {busy, ready}, 2'b00);

    run_build(1'b0, 1'b0, 1'b0);
    run_vectors("lookup");

    // 256 back-to-back lookups
    req_valid = 1'b1;
    for (int x = 0; x < 256; x++) begin
      req_addr = 8'(x);
      tick();
      chk("b2b", {23'd0, rsp_valid, FWD_SBOX[rsp_data]}, {23'd0, 1'b1, 8'(x)});
    end
    req_valid = 1'b0;
    tick();
    chk("b2b_end", rsp_valid, 1'b0);

    // start in READY with a request in flight, then mid-FILL start ignored
    req_valid = 1'b1;
    req_addr  = 8'h7C;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    req_valid = 1'b0;
    chk("rebuild_inflight", {ready, rsp_valid, rsp_data}, {1'b0, 1'b1, 8'h01});
    run_build(1'b1, 1'b1, 1'b0);
    run_vectors("rebuild");

    // rst at cycle 150 of a build
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 150; c++) tick();
    rst       = 1'b1;
    req_valid = 1'b1;
    req_addr  = 8'h63;
    tick();
    chk("midrst_outs", {busy, ready, req_ready, rsp_valid, err}, 5'b0);
    chk("midrst_data", rsp_data, 8'h00);
    rst = 1'b0;
    tick();
    chk("midrst_ignore_req", {ready, rsp_valid}, 2'b00);
    req_valid = 1'b0;
    tick();
    run_build(1'b0, 1'b0, 1'b0);
    run_vectors("after_rst");

`ifdef INV_SBOX_SELFCHECK_EN
    run_build(1'b0, 1'b0, 1'b1);
    tick();
    chk("err_sticky", err, 1'b1);
    run_build(1'b0, 1'b0, 1'b0);
    run_vectors("after_err");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
